// File: rtl/aes_pkg.sv
// Shared AES definitions for the inverse key scheduler.
// Contents: round count, Rcon table and lookup, FSM state encoding,
// and GF(2^8) arithmetic helpers used by the S-box.
package aes_pkg;

  localparam int unsigned NUM_ROUNDS = 10;

  // Rcon for key-expansion steps 1..10 (index 0 is step 1).
  localparam logic [7:0] RCON [NUM_ROUNDS] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StExpand = 2'd1,
    StEmit   = 2'd2
  } state_e;

  // Rcon for a 1-based step number; 0 outside 1..10.
  function automatic logic [7:0] rcon_lookup(input logic [3:0] step);
    logic [7:0] rc;
    rc = 8'h00;
    case (step)
      4'd1:    rc = RCON[0];
      4'd2:    rc = RCON[1];
      4'd3:    rc = RCON[2];
      4'd4:    rc = RCON[3];
      4'd5:    rc = RCON[4];
      4'd6:    rc = RCON[5];
      4'd7:    rc = RCON[6];
      4'd8:    rc = RCON[7];
      4'd9:    rc = RCON[8];
      4'd10:   rc = RCON[9];
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gf_xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = 8'h00;
    x   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = gf_xtime(x);
    end
    return acc;
  endfunction

endpackage

// File: rtl/aes_inv_key_scheduler_g.sv
// AES key-schedule g function: SubWord(RotWord(w)) ^ {rcon, 00, 00, 00}.
// Ports: word_i - 32-bit word (byte 0 in [31:24]); rcon_i - round constant;
//        g_o - result word.
module aes_inv_key_scheduler_g (
  input  logic [31:0] word_i,
  input  logic [7:0]  rcon_i,
  output logic [31:0] g_o
);

  logic [31:0] rot;
  logic [31:0] sub;

  assign rot = {word_i[23:0], word_i[31:24]};

  for (genvar b = 0; b < 4; b++) begin : gen_sbox
    sbox u_sbox (
      .data_i (rot[8*b +: 8]),
      .data_o (sub[8*b +: 8])
    );
  end

  assign g_o = sub ^ {rcon_i, 24'h000000};

endmodule

// File: rtl/sbox.sv
// AES forward S-box, computed rather than tabulated.
// Ports: data_i - input byte; data_o - SubBytes(data_i).
module sbox
  import aes_pkg::*;
(
  input  logic [7:0] data_i,
  output logic [7:0] data_o
);

  logic [7:0] inv;
  logic [7:0] sq;

  // Multiplicative inverse as x^254 = x^2 * x^4 * ... * x^128 (maps 0 to 0).
  always_comb begin
    sq  = gf_mul(data_i, data_i);
    inv = sq;
    for (int i = 2; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
  end

  // Affine transform: b ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4 ^ 0x63.
  always_comb begin
    data_o = inv
           ^ {inv[6:0], inv[7]}
           ^ {inv[5:0], inv[7:6]}
           ^ {inv[4:0], inv[7:5]}
           ^ {inv[3:0], inv[7:4]}
           ^ 8'h63;
  end

endmodule

// File: rtl/aes_inv_key_scheduler.sv
// AES-128 inverse key scheduler. Accepts a cipher key, expands forward to the
// last round key (one step per cycle), then streams round keys 10 down to 0
// over a valid/ready handshake, stepping backwards one round per handshake.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   key_in/key_valid    - cipher key input (bit 0 = MSB), accepted when key_ready
//   key_ready           - high only while idle
//   flush               - synchronous abort back to idle
//   rk_out/rk_round     - current round key and its round index
//   rk_valid/rk_ready   - output handshake
module aes_inv_key_scheduler
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic [0:127] key_in,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic         flush,
  output logic [0:127] rk_out,
  output logic [3:0]   rk_round,
  output logic         rk_valid,
  input  logic         rk_ready
);

  state_e       state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [3:0]   round_q, round_d;

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] inv_w3;
  logic [31:0] g_in, g_out;
  logic [3:0]  rcon_step;
  logic [7:0]  rcon;
  logic [127:0] fwd_key, inv_key;

  assign w0 = key_q[127:96];
  assign w1 = key_q[95:64];
  assign w2 = key_q[63:32];
  assign w3 = key_q[31:0];

  assign inv_w3 = w3 ^ w2;

  // One g datapath shared by both directions. Forward step r uses the
  // counter value r-1; inverse from round r uses Rcon of step r.
  always_comb begin
    if (state_q == StExpand) begin
      g_in      = w3;
      rcon_step = round_q + 4'd1;
    end else begin
      g_in      = inv_w3;
      rcon_step = round_q;
    end
  end

  assign rcon = rcon_lookup(rcon_step);

  aes_inv_key_scheduler_g u_g (
    .word_i (g_in),
    .rcon_i (rcon),
    .g_o    (g_out)
  );

  always_comb begin
    logic [31:0] n0, n1, n2;
    n0      = w0 ^ g_out;
    n1      = w1 ^ n0;
    n2      = w2 ^ n1;
    fwd_key = {n0, n1, n2, w3 ^ n2};
    inv_key = {w0 ^ g_out, w1 ^ w0, w2 ^ w1, inv_w3};
  end

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    round_d = round_q;
    if (flush) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (key_valid) begin
            key_d   = key_in;
            round_d = 4'd0;
            state_d = StExpand;
          end
        end
        StExpand: begin
          key_d   = fwd_key;
          round_d = round_q + 4'd1;
          if (round_q == 4'(NUM_ROUNDS - 1)) state_d = StEmit;
        end
        StEmit: begin
          if (rk_ready) begin
            if (round_q == 4'd0) begin
              state_d = StIdle;
            end else begin
              key_d   = inv_key;
              round_d = round_q - 4'd1;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      key_q   <= '0;
      round_q <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      round_q <= round_d;
    end
  end

  assign key_ready = (state_q == StIdle);
  assign rk_valid  = (state_q == StEmit);
  assign rk_out    = key_q;
  assign rk_round  = round_q;

endmodule

// File: tb/tb_aes_inv_key_scheduler.sv
module tb_aes_inv_key_scheduler;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
  localparam logic [127:0] FIPS_K10 = 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6;
  localparam logic [127:0] FIPS_K1  = 128'ha0fafe17_88542cb1_23a33939_2a6c7605;
  localparam logic [127:0] ZERO_K10 = 128'hb4ef5bcb_3e92e211_23e951cf_6f8f188e;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [0:127] key_in;
  logic         key_valid;
  logic         key_ready;
  logic         flush;
  logic [0:127] rk_out;
  logic [3:0]   rk_round;
  logic         rk_valid;
  logic         rk_ready;

  always #5 clk = ~clk;

  aes_inv_key_scheduler dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_in    (key_in),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .flush     (flush),
    .rk_out    (rk_out),
    .rk_round  (rk_round),
    .rk_valid  (rk_valid),
    .rk_ready  (rk_ready)
  );

  int checks = 0;
  int errors = 0;

  logic [131:0] exp_q[$];
  logic [7:0]   sbox_ref[256];
  logic [127:0] ref_rk[11];

  task automatic check(input string name, input logic [135:0] act, input logic [135:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  function automatic int rotl8(input int v, input int s);
    return ((v << s) | (v >> (8 - s))) & 8'hff;
  endfunction

  // S-box from the classic generator walk over (3^k, 3^-k).
  task automatic init_sbox();
    int p, q, x;
    p = 1;
    q = 1;
    do begin
      p = (p ^ (p << 1) ^ (((p & 8'h80) != 0) ? 8'h1b : 0)) & 8'hff;
      q = q ^ (q << 1);
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      q = q & 8'hff;
      if ((q & 8'h80) != 0) q = q ^ 8'h09;
      x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
      sbox_ref[p] = 8'((x ^ 8'h63) & 8'hff);
    end while (p != 1);
    sbox_ref[0] = 8'h63;
  endtask

  // Textbook forward expansion into 44 words; round key r = words 4r..4r+3.
  task automatic compute_ref(input logic [127:0] k);
    logic [31:0] w[44];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_ref[t[31:24]], sbox_ref[t[23:16]], sbox_ref[t[15:8]], sbox_ref[t[7:0]]}
            ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) ref_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops the scoreboard on every handshake, checks stall stability.
  logic         stall;
  logic [131:0] held;
  initial begin
    logic [131:0] e;
    stall = 1'b0;
    held  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall = 1'b0;
      end else begin
        if (stall) check("stall_stable", {rk_round, rk_out}, held);
        if (rk_valid && rk_ready && !flush) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rk: got round %0d key %h want none", rk_round, rk_out);
          end else begin
            e = exp_q.pop_front();
            check("scoreboard", {rk_round, rk_out}, e);
          end
        end
        stall = rk_valid && !rk_ready && !flush;
        held  = {rk_round, rk_out};
      end
    end
  end

  task automatic send_key(input logic [127:0] k, input bit b2b);
    int n;
    n = 0;
    while (!key_ready && n < 50) begin
      tick();
      n++;
    end
    check("key_ready_wait", key_ready, 1'b1);
    if (b2b) check("b2b_no_wait", n, 0);
    key_in    = k;
    key_valid = 1'b1;
    compute_ref(k);
    for (int r = 10; r >= 0; r--) exp_q.push_back({4'(r), ref_rk[r]});
    tick();
    key_valid = 1'b0;
    key_in    = {$urandom(), $urandom(), $urandom(), $urandom()};
    check("key_accepted", key_ready, 1'b0);
  endtask

  task automatic run_key(input logic [127:0] k, input bit rand_ready, input bit interfere,
                         input bit b2b, input bit kat, input logic [127:0] k10_exp,
                         input bit chk_k1, input logic [127:0] k1_exp);
    int n;
    send_key(k, b2b);
    for (int i = 1; i <= 10; i++) begin
      rk_ready  = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (interfere && $urandom_range(0, 2) == 0) begin
        key_valid = 1'b1;
        key_in    = {$urandom(), $urandom(), $urandom(), $urandom()};
      end
      tick();
      key_valid = 1'b0;
      check("rk_valid_latency", rk_valid, 1'(i == 10));
    end
    if (kat) check("k10_kat", {rk_round, rk_out}, {4'd10, k10_exp});
    n = 0;
    while (!key_ready && n < 300) begin
      if (chk_k1 && rk_valid && rk_round == 4'd1) check("k1_kat", rk_out, k1_exp);
      if (rk_valid && rk_round == 4'd0) check("k0_is_key", rk_out, k);
      rk_ready  = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      key_valid = interfere ? 1'($urandom_range(0, 1)) : 1'b0;
      key_in    = {$urandom(), $urandom(), $urandom(), $urandom()};
      tick();
      n++;
    end
    key_valid = 1'b0;
    check("emit_done", key_ready, 1'b1);
    check("rk_valid_idle", rk_valid, 1'b0);
    if (!rand_ready) check("emit_cycles", n, 11);
    check("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    logic [127:0] k;
    int n;
    init_sbox();
    key_in    = '0;
    key_valid = 1'b0;
    flush     = 1'b0;
    rk_ready  = 1'b0;
    #2 rst_n  = 1'b0;
    #2;
    check("reset_state", {key_ready, rk_valid, rk_round, rk_out}, {1'b1, 1'b0, 4'd0, 128'd0});
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Known-answer, full-rate consumer.
    run_key(FIPS_KEY, 1'b0, 1'b0, 1'b0, 1'b1, FIPS_K10, 1'b1, FIPS_K1);
    // Back-to-back, random backpressure.
    run_key(FIPS_KEY, 1'b1, 1'b0, 1'b1, 1'b1, FIPS_K10, 1'b1, FIPS_K1);
    // Foreign key_valid pulses during expand and emit.
    run_key(FIPS_KEY, 1'b1, 1'b1, 1'b1, 1'b1, FIPS_K10, 1'b1, FIPS_K1);

    // Flush with a handshake at round 5.
    k = {$urandom(), $urandom(), $urandom(), $urandom()};
    send_key(k, 1'b0);
    n = 0;
    while (!(rk_valid && rk_round == 4'd5) && n < 200) begin
      rk_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    check("reach_round5", {rk_valid, rk_round}, {1'b1, 4'd5});
    rk_ready = 1'b1;
    flush    = 1'b1;
    tick();
    flush = 1'b0;
    exp_q.delete();
    check("flush_valid", rk_valid, 1'b0);
    check("flush_ready", key_ready, 1'b1);
    tick();
    check("flush_stays_idle", rk_valid, 1'b0);

    // Reset in the middle of expansion.
    k = {$urandom(), $urandom(), $urandom(), $urandom()};
    send_key(k, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("midreset_out", {key_ready, rk_valid, rk_round, rk_out}, {1'b1, 1'b0, 4'd0, 128'd0});
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    run_key(128'd0, 1'b0, 1'b0, 1'b0, 1'b1, ZERO_K10, 1'b0, '0);

    // Random keys, random backpressure and interference.
    for (int t = 0; t < 6; t++) begin
      k = {$urandom(), $urandom(), $urandom(), $urandom()};
      run_key(k, 1'b1, 1'(t % 2), 1'b1, 1'b0, '0, 1'b0, '0);
    end

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_inv_key_scheduler.md
AES_INV_KEY_SCHEDULER -- requirements
Module: aes_inv_key_scheduler

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port key_in, input, [0:127]: cipher key; bit 0 is MSB; w0 = key_in[0+:32] through w3 = key_in[96+:32].
REQ-004 SHALL have port key_valid, input, 1 bit: key_in is valid.
REQ-005 SHALL have port key_ready, output, 1 bit: the block can accept a key; high only in IDLE.
REQ-006 SHALL have port flush, input, 1 bit: synchronous abort.
REQ-007 SHALL have port rk_out, output, [0:127]: current round key, same word and byte ordering as key_in.
REQ-008 SHALL have port rk_round, output, 4 bits: round index of rk_out (10 down to 0).
REQ-009 SHALL have port rk_valid, output, 1 bit: rk_out and rk_round are valid.
REQ-010 SHALL have port rk_ready, input, 1 bit: the consumer accepts the current round key.

Function
REQ-011 SHALL implement a three-state FSM with states IDLE, EXPAND and EMIT.
REQ-012 SHALL accept a key in IDLE when key_valid=1 (key_ready=1): register key_in, clear the round counter to 0, and go to EXPAND.
REQ-013 SHALL, in EXPAND, perform one forward FIPS-197 step per cycle, with Rcon for step r (1..10) = 01,02,04,08,10,20,40,80,1B,36:
  - g(w) = SubWord(RotWord(w)) XOR {Rcon,00,00,00}
  - w0' = w0^g(w3), w1' = w1^w0', w2' = w2^w1', w3' = w3^w2'
REQ-014 SHALL go from EXPAND to EMIT after the 10th step, so rk_valid rises exactly 10 cycles after the key-accept edge, with rk_out = K10 and rk_round = 10.
REQ-015 SHALL hold rk_out and rk_round stable in EMIT while rk_valid=1 and rk_ready=0.
REQ-016 SHALL, on each EMIT handshake (rk_valid & rk_ready) with rk_round > 0, perform one inverse step to K(r-1) in the same edge and present it next cycle with rk_valid still high (no bubble):
  - w3' = w3^w2, w2' = w2^w1, w1' = w1^w0
  - w0' = w0 ^ g(w3'), using Rcon for step r
REQ-017 SHALL, on the handshake with rk_round = 0, go to IDLE: rk_valid=0 and key_ready=1 on the next cycle.
REQ-018 SHALL ignore key_valid when not in IDLE; the key is not latched.
REQ-019 SHALL, when flush=1 in any state, go to IDLE on the next edge, clear rk_valid, and discard any in-progress handshake; flush takes priority over key_valid and rk_ready in the same cycle.
REQ-020 SHALL keep the round counter within 0..10; values 11..15 are never reached.
REQ-021 SHALL drive rk_valid=0 in IDLE and EXPAND; rk_out is don't-care there but SHALL not be X after reset.

Reset
REQ-022 SHALL, on rst_n=0, go immediately to IDLE with key_ready=1, rk_valid=0, rk_out=0, rk_round=0, and the key register and counter at 0.
REQ-023 SHALL abandon any EXPAND or EMIT sequence on mid-operation reset; the first key accepted after deassertion restarts cleanly.

Structure
REQ-024 SHALL put the Rcon table (10 x 8 bit), the FSM state encoding, and NUM_ROUNDS=10 in the shared package aes_pkg.
REQ-025 SHALL use one shared g datapath (four instances of the existing sbox module), with its input word muxed between w3 (forward) and w3^w2 (inverse); no second S-box set.

Verification
REQ-026 SHALL cover these directed scenarios:
  - Key 2b7e1516_28aed2a6_abf71588_09cf4f3c, rk_ready=1 -> after 10 cycles K10 = d014f9a8_c9ee2589_e13f0cc8_b6630ca6 (round 10), then one key per cycle, K1 = a0fafe17_88542cb1_23a33939_2a6c7605, K0 = the input key, then key_ready=1.
  - Same key, rk_ready toggled randomly -> identical K10..K0 sequence; rk_out stable while stalled.
  - key_valid pulsed with a different key during EXPAND and EMIT -> ignored; sequence unchanged.
  - flush asserted together with rk_ready at round 5 -> next cycle IDLE, rk_valid=0, no round-4 key emitted.
  - rst_n asserted at EXPAND step 6 -> outputs zero immediately; a new all-zero key then yields K10 = b4ef5bcb_3e92e211_23e951cf_6f8f188e.
  - Back-to-back keys (new key_valid on the cycle key_ready rises) -> second expansion starts without a lost cycle.
